// File: rtl/lsu_mc_pkg.sv
// lsu_mc_pkg: state encodings, width/error codes and lane helper for the load/store unit
package lsu_mc_pkg;
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    REQ  = 4'b0010,
    RDW  = 4'b0100,
    RESP = 4'b1000
  } state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [2:0] F3_X  = 3'b111;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_WIDTH    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
  function automatic int lane_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/lsu_mc_if.sv
// lsu_mc_if: CPU request/response and memory bus signals of the load/store unit
interface lsu_mc_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_store;
  logic [2:0]          req_funct3;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_data;
  logic [1:0]          resp_err;
  logic [ADDR_W-1:0]   Address;
  logic                MemWrite;
  logic                MemRead;
  logic [DATA_W-1:0]   Write_data;
  logic [DATA_W/8-1:0] Write_strb;
  logic                Mem_Req_Ready;
  logic [DATA_W-1:0]   Read_data;
  logic                Read_data_Valid;
  logic                Read_data_Ready;
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output Mem_Req_Ready, Read_data, Read_data_Valid,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready
  );
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  Mem_Req_Ready, Read_data, Read_data_Valid,
    output req_ready, resp_valid, resp_data, resp_err,
    output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane shift of store data/strobe and load extraction/extension
import lsu_mc_pkg::*;
module lsu_lane_align #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                funct3,
  input  logic [lane_w(DATA_W)-1:0] lane,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata,
  output logic [DATA_W-1:0]         wdata_sh,
  output logic [DATA_W/8-1:0]       strb,
  output logic [DATA_W-1:0]         rdata_ext
);
  localparam int SW = DATA_W / 8;
  logic [7:0]        base;
  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] mask;
  logic              msb;
  always_comb begin
    base = funct3[1:0] == 2'd0 ? 8'h01 : funct3[1:0] == 2'd1 ? 8'h03 : funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    strb = SW'(base) << lane;
    wdata_sh = wdata << {lane, 3'b000};
    rsh = rdata >> {lane, 3'b000};
    mask = funct3[1:0] == 2'd0 ? DATA_W'(64'hFF) : funct3[1:0] == 2'd1 ? DATA_W'(64'hFFFF) :
           funct3[1:0] == 2'd2 ? DATA_W'(64'hFFFF_FFFF) : '1;
    msb = funct3[1:0] == 2'd0 ? rsh[7] : funct3[1:0] == 2'd1 ? rsh[15] : funct3[1:0] == 2'd2 ? rsh[31] : 1'b0;
    rdata_ext = (rsh & mask) | ({DATA_W{~funct3[2] & msb}} & ~mask);
  end
endmodule

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit with one-hot FSM, lane alignment and read timeout
import lsu_mc_pkg::*;
module lsu_mc #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input logic     clk,
  input logic     rst,
  lsu_mc_if.slave bus
);
  localparam int LW = lane_w(DATA_W);
  localparam int CW = $clog2(TIMEOUT);
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          f3_q;
  logic [LW-1:0]       lane_q;
  logic                store_q;
  logic [2:0]          f3;
  logic [LW-1:0]       lane;
  logic                illegal;
  logic                misaligned;
  logic [1:0]          err;
  logic [DATA_W-1:0]   wsh;
  logic [DATA_W-1:0]   rext;
  logic [DATA_W/8-1:0] strb;
  // alignment uses the live request while idle and the latched one afterwards
  always_comb begin
    f3 = state == IDLE ? bus.req_funct3 : f3_q;
    lane = state == IDLE ? bus.req_addr[LW-1:0] : lane_q;
    illegal = bus.req_funct3 == F3_X || (bus.req_store && bus.req_funct3[2]) ||
              (DATA_W == 32 && (bus.req_funct3 == F3_D || bus.req_funct3 == F3_WU));
    misaligned = bus.req_funct3[1:0] == 2'd1 ? bus.req_addr[0] :
                 bus.req_funct3[1:0] == 2'd2 ? |bus.req_addr[1:0] :
                 bus.req_funct3[1:0] == 2'd3 ? |bus.req_addr[2:0] : 1'b0;
    err = illegal ? ERR_WIDTH : misaligned ? ERR_MISALIGN : ERR_NONE;
  end
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3(f3), .lane(lane), .wdata(bus.req_wdata), .rdata(bus.Read_data),
    .wdata_sh(wsh), .strb(strb), .rdata_ext(rext)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      f3_q <= '0;
      lane_q <= '0;
      store_q <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data <= '0;
      bus.resp_err <= ERR_NONE;
      bus.MemRead <= 1'b0;
      bus.MemWrite <= 1'b0;
      bus.Address <= '0;
      bus.Write_data <= '0;
      bus.Write_strb <= '0;
      bus.Read_data_Ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          f3_q <= bus.req_funct3;
          lane_q <= lane;
          store_q <= bus.req_store;
          bus.req_ready <= 1'b0;
          if (err != ERR_NONE) begin
            state <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err <= err;
          end else begin
            state <= REQ;
            bus.MemRead <= ~bus.req_store;
            bus.MemWrite <= bus.req_store;
            bus.Address <= {bus.req_addr[ADDR_W-1:LW], LW'(0)};
            bus.Write_data <= bus.req_store ? wsh : '0;
            bus.Write_strb <= bus.req_store ? strb : '0;
          end
        end
        REQ: if (bus.Mem_Req_Ready) begin
          state <= store_q ? RESP : RDW;
          bus.resp_valid <= store_q;
          bus.Read_data_Ready <= ~store_q;
          cnt <= '0;
          bus.MemRead <= 1'b0;
          bus.MemWrite <= 1'b0;
          bus.Address <= '0;
          bus.Write_data <= '0;
          bus.Write_strb <= '0;
        end
        RDW: if (bus.Read_data_Valid || cnt == CW'(TIMEOUT - 1)) begin
          state <= RESP;
          bus.resp_valid <= 1'b1;
          bus.Read_data_Ready <= 1'b0;
          bus.resp_data <= bus.Read_data_Valid ? rext : '0;
          bus.resp_err <= bus.Read_data_Valid ? ERR_NONE : ERR_TIMEOUT;
        end else begin
          cnt <= cnt + CW'(1);
        end
        RESP: begin
          state <= IDLE;
          bus.req_ready <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_data <= '0;
          bus.resp_err <= ERR_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: directed vectors for 32-bit (TIMEOUT=4) and 64-bit load/store units
module tb_lsu_mc;
  logic clk;
  logic rst;
  int nvec;
  int nerr;
  int lat;
  int rd_cyc;
  int rdy_cyc;
  bit addr_ok;
  bit saw_mem;
  bit pulse_ok;
  bit seen;
  logic [63:0] m_addr;
  logic [63:0] m_strb;
  logic [63:0] m_wd;
  logic [63:0] r_data;
  logic [1:0]  r_err;
  lsu_mc_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  lsu_mc_if #(.DATA_W(64), .ADDR_W(32)) b64 ();
  lsu_mc #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (.clk(clk), .rst(rst), .bus(b32));
  lsu_mc #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8)) u64 (.clk(clk), .rst(rst), .bus(b64));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // memory holds off Mem_Req_Ready for rwait cycles; give=0 never returns read data
  task automatic run32(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int rwait, input bit give);
    int w;
    w = rwait; lat = -1; rd_cyc = 0; rdy_cyc = 0; addr_ok = 1; saw_mem = 0; r_data = 0; r_err = 0;
    m_addr = 0; m_strb = 0; m_wd = 0;
    b32.req_valid = 1; b32.req_store = st; b32.req_funct3 = f3; b32.req_addr = a;
    b32.req_wdata = wd; b32.Read_data = rd;
    step();
    b32.req_valid = 0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (b32.MemRead | b32.MemWrite) begin
        if (!saw_mem) begin
          m_addr = 64'(b32.Address); m_strb = 64'(b32.Write_strb); m_wd = 64'(b32.Write_data);
        end else if (64'(b32.Address) !== m_addr) addr_ok = 0;
        saw_mem = 1;
        rd_cyc += int'(b32.MemRead);
      end
      rdy_cyc += int'(b32.Read_data_Ready);
      if (b32.resp_valid) begin
        lat = c; r_data = 64'(b32.resp_data); r_err = b32.resp_err;
      end
      b32.Mem_Req_Ready = (b32.MemRead | b32.MemWrite) && w == 0;
      if ((b32.MemRead | b32.MemWrite) && w > 0) w--;
      b32.Read_data_Valid = give && b32.Read_data_Ready;
      step();
    end
    pulse_ok = lat >= 0 && !b32.resp_valid;
    b32.Mem_Req_Ready = 0; b32.Read_data_Valid = 0;
  endtask
  // zero-wait memory with Read_data_Valid held high throughout
  task automatic run64(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [63:0] wd,
                       input logic [63:0] rd);
    lat = -1; saw_mem = 0; r_data = 0; r_err = 0; m_addr = 0; m_strb = 0; m_wd = 0;
    b64.req_valid = 1; b64.req_store = st; b64.req_funct3 = f3; b64.req_addr = a;
    b64.req_wdata = wd; b64.Read_data = rd; b64.Mem_Req_Ready = 1; b64.Read_data_Valid = 1;
    step();
    b64.req_valid = 0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      if ((b64.MemRead | b64.MemWrite) && !saw_mem) begin
        saw_mem = 1; m_addr = 64'(b64.Address); m_strb = 64'(b64.Write_strb); m_wd = b64.Write_data;
      end
      if (b64.resp_valid) begin
        lat = c; r_data = b64.resp_data; r_err = b64.resp_err;
      end
      step();
    end
    b64.Mem_Req_Ready = 0; b64.Read_data_Valid = 0;
  endtask
  initial begin
    nvec = 0; nerr = 0; rst = 1;
    b32.req_valid = 0; b32.req_store = 0; b32.req_funct3 = 0; b32.req_addr = 0; b32.req_wdata = 0;
    b32.Mem_Req_Ready = 0; b32.Read_data = 0; b32.Read_data_Valid = 0;
    b64.req_valid = 0; b64.req_store = 0; b64.req_funct3 = 0; b64.req_addr = 0; b64.req_wdata = 0;
    b64.Mem_Req_Ready = 0; b64.Read_data = 0; b64.Read_data_Valid = 0;
    step(); step();
    chk("rst_req_ready", b32.req_ready, 1);
    chk("rst_resp_valid", b32.resp_valid, 0);
    chk("rst_mem_strobes", {b32.MemRead, b32.MemWrite, b32.Read_data_Ready}, 0);
    chk("rst_address", b32.Address, 0);
    chk("rst_strb", b32.Write_strb, 0);
    rst = 0;
    step();
    run32(0, 3'b000, 32'h103, 0, 32'h80FF_0000, 0, 1);
    chk("lb_data", r_data, 64'hFFFF_FF80);
    chk("lb_err", r_err, 0);
    chk("lb_lat", lat, 3);
    chk("lb_addr", m_addr, 64'h100);
    chk("lb_pulse", pulse_ok, 1);
    run32(1, 3'b001, 32'h22, 32'h1234_ABCD, 0, 0, 1);
    chk("sh_addr", m_addr, 64'h20);
    chk("sh_strb", m_strb, 64'hC);
    chk("sh_wdata", m_wd, 64'hABCD_0000);
    chk("sh_lat", lat, 2);
    chk("sh_data", r_data, 0);
    run32(0, 3'b010, 32'h40, 0, 32'hDEAD_BEEF, 5, 1);
    chk("wait_rd_cycles", rd_cyc, 6);
    chk("wait_addr_stable", addr_ok, 1);
    chk("wait_addr", m_addr, 64'h40);
    chk("wait_lat", lat, 8);
    chk("wait_data", r_data, 64'hDEAD_BEEF);
    run32(0, 3'b010, 32'h2, 0, 0, 0, 1);
    chk("lw_mis_err", r_err, 1);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_nomem", saw_mem, 0);
    run32(0, 3'b011, 32'h0, 0, 0, 0, 1);
    chk("ld32_err", r_err, 2);
    chk("ld32_lat", lat, 1);
    run32(0, 3'b011, 32'h1, 0, 0, 0, 1);
    chk("ld32_prio_err", r_err, 2);
    run32(1, 3'b100, 32'h0, 0, 0, 0, 1);
    chk("sbu_err", r_err, 2);
    run32(0, 3'b110, 32'h0, 0, 0, 0, 1);
    chk("lwu32_err", r_err, 2);
    run32(0, 3'b101, 32'h6, 0, 32'h8001_0000, 0, 1);
    chk("lhu_data", r_data, 64'h8001);
    run32(0, 3'b001, 32'h6, 0, 32'h8001_0000, 0, 1);
    chk("lh_data", r_data, 64'hFFFF_8001);
    run32(1, 3'b000, 32'h1, 32'h1122_3344, 0, 0, 1);
    chk("sb_strb", m_strb, 64'h2);
    chk("sb_wdata", m_wd, 64'h2233_4400);
    run32(0, 3'b010, 32'h10, 0, 32'h55, 0, 0);
    chk("to_err", r_err, 3);
    chk("to_lat", lat, 6);
    chk("to_rdw_cycles", rdy_cyc, 4);
    chk("to_data", r_data, 0);
    b32.Read_data = 32'h1234_5678; b32.Read_data_Valid = 1; seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= b32.resp_valid | ~b32.req_ready;
    end
    b32.Read_data_Valid = 0;
    chk("late_rdv_ignored", seen, 0);
    run32(0, 3'b000, 32'h0, 0, 32'h7F, 0, 1);
    chk("after_to_data", r_data, 64'h7F);
    chk("after_to_lat", lat, 3);
    b32.Mem_Req_Ready = 1; b32.req_valid = 1; b32.req_store = 0; b32.req_funct3 = 3'b010; b32.req_addr = 32'h10;
    step();
    b32.req_valid = 0;
    step();
    chk("rst_rdw_entered", b32.Read_data_Ready, 1);
    rst = 1;
    step();
    rst = 0;
    b32.Mem_Req_Ready = 0;
    chk("rst_rdw_idle", b32.req_ready, 1);
    chk("rst_rdw_rdy", b32.Read_data_Ready, 0);
    seen = b32.resp_valid;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= b32.resp_valid;
    end
    chk("rst_rdw_noresp", seen, 0);
    run64(0, 3'b110, 32'h4, 0, 64'hF000_0000_0000_0000);
    chk("lwu64_data", r_data, 64'h0000_0000_F000_0000);
    chk("lwu64_err", r_err, 0);
    chk("lwu64_lat", lat, 3);
    run64(0, 3'b010, 32'h4, 0, 64'hF000_0000_0000_0000);
    chk("lw64_data", r_data, 64'hFFFF_FFFF_F000_0000);
    run64(0, 3'b011, 32'h8, 0, 64'h0123_4567_89AB_CDEF);
    chk("ld64_data", r_data, 64'h0123_4567_89AB_CDEF);
    chk("ld64_addr", m_addr, 64'h8);
    run64(1, 3'b010, 32'h4, 64'hCAFE_F00D, 0);
    chk("sw64_strb", m_strb, 64'hF0);
    chk("sw64_wdata", m_wd, 64'hCAFE_F00D_0000_0000);
    run64(1, 3'b011, 32'h10, 64'h1111_2222_3333_4444, 0);
    chk("sd64_strb", m_strb, 64'hFF);
    chk("sd64_addr", m_addr, 64'h10);
    run64(0, 3'b011, 32'h4, 0, 0);
    chk("ld64_mis_err", r_err, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
